// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns one RV32I load or store from the execute
// stage into a single request/grant/rvalid bus transaction, with byte-lane
// steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  input  logic        lsu_wr_en,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [4:0]  lsu_rd_addr,
  output logic        lsu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        lsu_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;

  logic        err_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        stall_c;
  logic        accept_c;
  logic        load_done_c;
  logic [31:0] rshift_c;
  logic [31:0] load_c;

  // Legality check: illegal width codes first, then natural alignment.
  always_comb begin
    logic illegal;
    logic misaligned;
    if (lsu_wr_en) illegal = lsu_funct3[2] | (lsu_funct3[1:0] == 2'b11);
    else           illegal = (lsu_funct3[1:0] == 2'b11) | (lsu_funct3 == 3'b110);
    case (lsu_funct3[1:0])
      2'b01:   misaligned = lsu_addr[0];
      2'b10:   misaligned = (lsu_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    err_c = illegal | misaligned;
  end

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    case (lsu_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lsu_addr[1:0];
        wdata_c = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {lsu_addr[1], 1'b0};
        wdata_c = {2{lsu_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = lsu_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and combinational stall/handshake decode.
  always_comb begin
    state_nxt   = state;
    stall_c     = 1'b0;
    accept_c    = 1'b0;
    load_done_c = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req_valid && !err_c) begin
          accept_c  = 1'b1;
          stall_c   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus_gnt) begin
          if (we_q) begin
            stall_c   = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        stall_c = 1'b1;
        if (bus_rvalid) begin
          stall_c     = 1'b0;
          load_done_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the accepted operation; held stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rd_q     <= '0;
    end else if (accept_c) begin
      addr_q   <= lsu_addr;
      funct3_q <= lsu_funct3;
      we_q     <= lsu_wr_en;
      wdata_q  <= wdata_c;
      be_q     <= be_c;
      rd_q     <= lsu_rd_addr;
    end
  end

  // Bus outputs are live only while requesting; zero otherwise.
  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be_q : '0;
  assign bus_wdata = bus_we ? wdata_q : '0;
  assign lsu_stall = stall_c & ~rst;

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    rshift_c = bus_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_c = {{24{rshift_c[7]}}, rshift_c[7:0]};
      3'b001:  load_c = {{16{rshift_c[15]}}, rshift_c[15:0]};
      3'b100:  load_c = {24'd0, rshift_c[7:0]};
      3'b101:  load_c = {16'd0, rshift_c[15:0]};
      default: load_c = bus_rdata;
    endcase
  end

  // Registered writeback and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      lsu_err <= 1'b0;
    end else begin
      wb_en   <= load_done_c && (rd_q != 5'd0);
      wb_addr <= (load_done_c && (rd_q != 5'd0)) ? rd_q : '0;
      wb_data <= (load_done_c && (rd_q != 5'd0)) ? load_c : '0;
      lsu_err <= (state == IDLE) && lsu_req_valid && err_c;
    end
  end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 lsu_req_valid  in  1  execute stage presents a memory operation (load or store).
REQ-005 lsu_wr_en  in  1  1 = store, 0 = load.
REQ-006 lsu_funct3  in  3  RV32I width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 lsu_addr  in  32  effective byte address (rs1 + imm).
REQ-008 lsu_wdata  in  32  store data (rs2).
REQ-009 lsu_rd_addr  in  5  load destination register.
REQ-010 lsu_stall  out  1  hold the pipeline; the inputs stay stable while the stall is high.
REQ-011 bus_req, bus_we  out  1 each  bus request and write flag.
REQ-012 bus_addr  out  32  word-aligned address, with [1:0] = 0.
REQ-013 bus_be  out  4  byte enables; bus_wdata  out  32  lane-replicated store data.
REQ-014 bus_gnt, bus_rvalid  in  1 each; bus_rdata  in  32.
REQ-015 wb_en  out  1; wb_addr  out  5; wb_data  out  32  load writeback.
REQ-016 lsu_err  out  1  one-cycle pulse on a misaligned access or an illegal funct3.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and WAIT_R.
REQ-018 IDLE: when lsu_req_valid is high and the access is legal, the block SHALL capture addr, funct3, we, wdata and rd, go to REQ, and drive lsu_stall = 1 combinationally in the same cycle.
REQ-019 Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or illegal funct3 (loads 011/110/111, stores >= 011): no bus activity, stall = 0, lsu_err = 1 in the next cycle, FSM stays in IDLE.
REQ-020 REQ: bus_req = 1 with addr, we, be and wdata held stable until the cycle in which bus_gnt = 1.
REQ-021 REQ with bus_gnt and a store: the store completes in that cycle, lsu_stall = 0 combinationally, next state IDLE.
REQ-022 REQ with bus_gnt and a load: next state WAIT_R, stall stays 1.
REQ-023 WAIT_R with bus_rvalid: lsu_stall = 0 combinationally, next state IDLE, and wb_en/wb_addr/wb_data registered, so valid for one cycle after rvalid.
REQ-024 bus_rvalid SHALL be ignored outside WAIT_R; bus_gnt SHALL be ignored outside REQ.
REQ-025 Byte enables: SB gives be = 4'b0001 << addr[1:0]; SH gives 4'b0011 << {addr[1],1'b0}; SW gives 4'b1111; a load uses the same be as the matching width.
REQ-026 Store data: SB gives {4{wdata[7:0]}}; SH gives {2{wdata[15:0]}}; SW gives wdata.
REQ-027 Load extract: select the byte or halfword lane from rdata by the captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
REQ-028 A load with rd = 0 SHALL complete on the bus, but wb_en SHALL stay 0.
REQ-029 The block SHALL hold at most one outstanding transaction; a new request is accepted only in IDLE.
REQ-030 When idle, the bus outputs SHALL be zero: bus_req = 0, be = 0, and the other bus outputs 0.

Reset
REQ-031 While rst is asserted: FSM in IDLE, and all outputs (lsu_stall, bus_*, wb_*, lsu_err) are 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no writeback; a late bus_rvalid after reset SHALL be ignored.
REQ-033 The first request SHALL be accepted in the first clock edge after rst deasserts.

Verification
REQ-034 SW addr 0x100, wdata 0xDEADBEEF, gnt after 2 cycles -> bus_req high 3 cycles, be 1111, addr 0x100, stall drops in the gnt cycle, no wb_en.
REQ-035 LB addr 0x203, rdata 0x80FF_0011, rvalid 1 cycle after gnt -> be 1000, wb_data 0xFFFF_FF80, wb_en one cycle.
REQ-036 LHU addr 0x202, rdata 0x8001_1234 -> be 1100, wb_data 0x0000_8001; SH addr 0x206, wdata 0x0000_ABCD -> be 1100, bus_wdata 0xABCD_ABCD.
REQ-037 LW addr 0x101 -> no bus_req, stall 0, lsu_err pulse next cycle; funct3 011 load -> same response.
REQ-038 LW rd = 0 -> bus transaction occurs, wb_en stays 0; a stray rvalid while in IDLE causes no wb_en.
REQ-039 Assert rst in WAIT_R, then rvalid arrives -> outputs 0, no wb_en, next request accepted normally.
